tsc_mem_responder: RTL and testbench

- Memory-side responder for the TSC multi-cycle CPU bus: services the CPU's readM/writeM requests against an internal word-addressed RAM.
- Returns read data with an inputReady pulse, and completes writes with an ackOutput pulse, after a programmable latency.
- Sits between the CPU top level and the testbench; also provides a backdoor preload port so the bench can load programs and data.

---
 rtl/tsc_mem_responder_pkg.sv | 26 ++
 rtl/tsc_mem_array.sv | 47 ++++
 rtl/tsc_mem_responder.sv | 142 ++++++++++++++
 tb/tb_tsc_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tsc_mem_responder_pkg
// Description : Shared widths, opcode and state encodings for the TSC memory
//               responder.
// Revision    : 1.0 - initial release
// ============================================================================
package tsc_mem_responder_pkg;

    localparam int MEM_WORD_WIDTH = 16;
    localparam int MEM_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        MRS_IDLE = 2'd0,
        MRS_WAIT = 2'd1,
        MRS_RESP = 2'd2,
        MRS_DONE = 2'd3
    } mrs_state_t;

    typedef enum logic {
        MR_OP_READ  = 1'b0,
        MR_OP_WRITE = 1'b1
    } mr_op_t;

endpackage
`default_nettype wire

// File: rtl/tsc_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : tsc_mem_array
// Description : Single-port synchronous-write RAM with a functional/backdoor
//               write mux and an asynchronous read path.
// Revision    : 1.0 - initial release
// ============================================================================
module tsc_mem_array #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  func_we,
    input  logic [DEPTH_LOG2-1:0] func_addr,
    input  logic [WORD_WIDTH-1:0] func_data,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [WORD_WIDTH-1:0] load_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data
);

    localparam int C_DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_WIDTH-1:0] r_mem [C_DEPTH];
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_waddr;
    logic [WORD_WIDTH-1:0] w_wdata;

    // Functional writes only happen while the responder is busy and loads
    // only while idle, so the two sources never contend.
    always_comb begin
        w_we    = func_we | load_we;
        w_waddr = func_we ? func_addr : load_addr;
        w_wdata = func_we ? func_data : load_data;
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/tsc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tsc_mem_responder
// Description : Memory-side responder for the TSC multi-cycle CPU bus with
//               programmable latency and a backdoor preload port.
// Revision    : 1.0 - initial release
// ============================================================================
module tsc_mem_responder
    import tsc_mem_responder_pkg::*;
#(
    parameter int WORD_WIDTH = MEM_WORD_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  readM,
    input  logic                  writeM,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] write_data,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  inputReady,
    output logic                  ackOutput,
    output logic                  busy,
    output logic                  err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [WORD_WIDTH-1:0] load_data
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "tsc_mem_responder: LATENCY must be within 1..15");
    end

    localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

    mrs_state_t            r_state;
    mrs_state_t            w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_data;
    mr_op_t                r_op;
    logic                  w_capture;
    logic                  w_access;
    logic                  w_req_conflict;
    logic                  w_out_of_range;
    logic                  w_load_we;
    logic                  w_func_we;
    logic                  w_err_nxt;
    logic [WORD_WIDTH-1:0] w_rd_data;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_capture      = 1'b0;
        w_access       = 1'b0;
        w_req_conflict = 1'b0;
        case (r_state)
            MRS_IDLE: begin
                if (readM && writeM) begin
                    w_req_conflict = 1'b1;
                end else if (readM || writeM) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = C_CNT_INIT;
                    w_state_nxt = MRS_WAIT;
                end
            end
            MRS_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = MRS_RESP;
                end
            end
            MRS_RESP: w_state_nxt = MRS_DONE;
            // Wait for the CPU to drop its level request so it is not serviced twice.
            MRS_DONE: begin
                if (!readM && !writeM) begin
                    w_state_nxt = MRS_IDLE;
                end
            end
            default: w_state_nxt = MRS_IDLE;
        endcase
    end

    assign w_out_of_range = (r_addr >> DEPTH_LOG2) != '0;
    assign w_load_we      = load_en && (r_state == MRS_IDLE);
    assign w_func_we      = w_access && (r_op == MR_OP_WRITE) && !w_out_of_range;
    assign w_err_nxt      = w_req_conflict
                          || (load_en && (r_state != MRS_IDLE))
                          || (w_access && w_out_of_range);

    tsc_mem_array #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .clk       (clk),
        .func_we   (w_func_we),
        .func_addr (r_addr[DEPTH_LOG2-1:0]),
        .func_data (r_data),
        .load_we   (w_load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .rd_addr   (r_addr[DEPTH_LOG2-1:0]),
        .rd_data   (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= MRS_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_data     <= '0;
            r_op       <= MR_OP_READ;
            read_data  <= '0;
            inputReady <= 1'b0;
            ackOutput  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            busy       <= (w_state_nxt != MRS_IDLE);
            inputReady <= w_access && (r_op == MR_OP_READ);
            ackOutput  <= w_access && (r_op == MR_OP_WRITE);
            err        <= w_err_nxt;
            if (w_capture) begin
                r_addr <= address;
                r_data <= write_data;
                r_op   <= writeM ? MR_OP_WRITE : MR_OP_READ;
            end
            if (w_access && (r_op == MR_OP_READ)) begin
                read_data <= w_out_of_range ? '0 : w_rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tsc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tsc_mem_responder
// Description : Scoreboard bench for tsc_mem_responder (LATENCY 2, 1 and 15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tsc_mem_responder;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        readM = 1'b0, writeM = 1'b0;
    logic [15:0] address = '0, write_data = '0;
    logic [15:0] read_data;
    logic        inputReady, ackOutput, busy, err;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [15:0] load_data = '0;

    logic        rd_b = 1'b0, wr_b = 1'b0;
    logic [15:0] addr_b = '0, wdata_b = '0;
    logic [15:0] rdata_l1, rdata_l15;
    logic        ir_l1, ack_l1, busy_l1, err_l1;
    logic        ir_l15, ack_l15, busy_l15, err_l15;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        bit          rd;
        bit          wr;
        bit          er;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tsc_mem_responder #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(8), .LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM), .address(address),
        .write_data(write_data), .read_data(read_data), .inputReady(inputReady),
        .ackOutput(ackOutput), .busy(busy), .err(err), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data));

    tsc_mem_responder #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(8), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .readM(rd_b), .writeM(wr_b), .address(addr_b),
        .write_data(wdata_b), .read_data(rdata_l1), .inputReady(ir_l1),
        .ackOutput(ack_l1), .busy(busy_l1), .err(err_l1), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data));

    tsc_mem_responder #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(8), .LATENCY(15)) dut_l15 (
        .clk(clk), .reset_n(reset_n), .readM(rd_b), .writeM(wr_b), .address(addr_b),
        .write_data(wdata_b), .read_data(rdata_l15), .inputReady(ir_l15),
        .ackOutput(ack_l15), .busy(busy_l15), .err(err_l15), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data));

    // Every pulse on the main instance must match the oldest pending expectation.
    always @(negedge clk) begin
        if (inputReady || ackOutput || err) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse cyc=%0d: got ir=%0b ack=%0b err=%0b, expected no pulse",
                         cyc, inputReady, ackOutput, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.due || inputReady != e.rd || ackOutput != e.wr || err != e.er
                    || (e.rd && read_data !== e.data)) begin
                    miscompares++;
                    $display("FAIL response: got cyc=%0d ir=%0b ack=%0b err=%0b data=%h, expected cyc=%0d ir=%0b ack=%0b err=%0b data=%h",
                             cyc, inputReady, ackOutput, err, read_data,
                             e.due, e.rd, e.wr, e.er, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int due, input bit rd, input bit wr, input bit er, input logic [15:0] data);
        exp_t e;
        e.due = due; e.rd = rd; e.wr = wr; e.er = er; e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [7:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic txn(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_data, input bit exp_err, input int hold,
                       input bit ld, input logic [7:0] ld_addr, input logic [15:0] ld_data);
        @(posedge clk); #1;
        readM = !wr; writeM = wr; address = addr; write_data = wdata;
        load_en = ld; load_addr = ld_addr; load_data = ld_data;
        push(cyc + 1 + L, !wr, wr, exp_err, exp_data);
        @(posedge clk); #1;
        load_en = 1'b0;
        check("busy_after_accept", busy, 1);
        repeat (2 + hold) @(posedge clk);
        #1;
        check("busy_until_drop", busy, 1);
        readM = 1'b0; writeM = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_drop", busy, 0);
    endtask

    initial begin
        int start, t1, t15, n1, n15;

        repeat (2) @(posedge clk);
        #1;
        check("rst_read_data", read_data, 0);
        check("rst_inputReady", inputReady, 0);
        check("rst_ackOutput", ackOutput, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); reset_n = 1'b1;

        do_load(8'h10, 16'h1234);
        do_load(8'h40, 16'h4444);
        do_load(8'h00, 16'h0F0F);
        do_load(8'h30, 16'h5555);
        do_load(8'h50, 16'h5050);

        txn(1'b0, 16'h0010, 16'h0, 16'h1234, 1'b0, 0, 1'b0, 8'h0, 16'h0);
        txn(1'b1, 16'h0020, 16'hBEEF, 16'h0, 1'b0, 0, 1'b0, 8'h0, 16'h0);
        txn(1'b0, 16'h0020, 16'h0, 16'hBEEF, 1'b0, 0, 1'b0, 8'h0, 16'h0);
        txn(1'b0, 16'h0010, 16'h0, 16'h1234, 1'b0, 5, 1'b0, 8'h0, 16'h0);

        // Both requests high in IDLE: three error pulses, nothing captured.
        @(posedge clk); #1;
        readM = 1'b1; writeM = 1'b1; address = 16'h0040; write_data = 16'hDEAD;
        for (int i = 1; i <= 3; i++) push(cyc + i, 1'b0, 1'b0, 1'b1, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check("conflict_busy", busy, 0);
        readM = 1'b0; writeM = 1'b0;
        txn(1'b0, 16'h0040, 16'h0, 16'h4444, 1'b0, 0, 1'b0, 8'h0, 16'h0);

        txn(1'b0, 16'h0100, 16'h0, 16'h0000, 1'b1, 0, 1'b0, 8'h0, 16'h0);
        txn(1'b1, 16'h0100, 16'hAAAA, 16'h0, 1'b1, 0, 1'b0, 8'h0, 16'h0);
        txn(1'b0, 16'h0000, 16'h0, 16'h0F0F, 1'b0, 0, 1'b0, 8'h0, 16'h0);

        txn(1'b0, 16'h0061, 16'h0, 16'h6161, 1'b0, 0, 1'b1, 8'h61, 16'h6161);

        // Backdoor load while busy is refused and flagged.
        @(posedge clk); #1;
        readM = 1'b1; address = 16'h0050;
        push(cyc + 2, 1'b0, 1'b0, 1'b1, 16'h0);
        push(cyc + 1 + L, 1'b1, 1'b0, 1'b0, 16'h5050);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = 8'h50; load_data = 16'h9999;
        @(posedge clk); #1;
        load_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        readM = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a write abandons it.
        writeM = 1'b1; address = 16'h0030; write_data = 16'h7777;
        @(posedge clk); #1;
        check("wait_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_read_data", read_data, 0);
        check("midrst_pulses", {inputReady, ackOutput, err}, 0);
        writeM = 1'b0;
        @(negedge clk); #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", busy, 0);
        txn(1'b0, 16'h0030, 16'h0, 16'h5555, 1'b0, 0, 1'b0, 8'h0, 16'h0);

        // Latency extremes on the side instances.
        @(posedge clk); #1;
        rd_b = 1'b1; addr_b = 16'h0010;
        start = cyc; t1 = -1; t15 = -1; n1 = 0; n15 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ir_l1) begin
                n1++;
                if (t1 < 0) t1 = cyc;
                check("l1_data", rdata_l1, 16'h1234);
                check("l1_flags", {ack_l1, err_l1}, 0);
            end
            if (ir_l15) begin
                n15++;
                if (t15 < 0) t15 = cyc;
                check("l15_data", rdata_l15, 16'h1234);
                check("l15_flags", {ack_l15, err_l15}, 0);
            end
        end
        check("l1_latency", t1, start + 2);
        check("l15_latency", t15, start + 16);
        check("l1_single_pulse", n1, 1);
        check("l15_single_pulse", n15, 1);
        @(posedge clk); #1;
        rd_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("lat_idle", {busy_l1, busy_l15}, 0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
